// File: rtl/if_id_fetch_queue_if.sv
// Handshake bundle between fetch, instruction memory, decode and the IF/ID queue.
// The master side drives requests and control. The slave side is the queue itself.
interface if_id_fetch_queue_if #(
  parameter int XLEN = 32
);
  logic            stall;
  logic            flush;
  logic            req_valid;
  logic [XLEN-1:0] req_pc;
  logic [31:0]     rsp_instr;
  logic            full;
  logic            valid_out;
  logic [XLEN-1:0] pc_out;
  logic [31:0]     instr_out;

  modport master (
    output stall, flush, req_valid, req_pc, rsp_instr,
    input  full, valid_out, pc_out, instr_out
  );

  modport slave (
    input  stall, flush, req_valid, req_pc, rsp_instr,
    output full, valid_out, pc_out, instr_out
  );
endinterface

// File: rtl/if_id_fetch_queue.sv
// IF/ID boundary: tracks fixed-latency fetches, pairs each returned word with its PC,
// and skids returns into a small FIFO while decode stalls. Fetch is throttled by credits.
module if_id_fetch_queue #(
  parameter int          XLEN    = 32,
  parameter int          DEPTH   = 2,
  parameter int          MEM_LAT = 1,
  parameter logic [31:0] NOP     = 32'h0000_0013
) (
  input logic                clk,
  input logic                rst,
  if_id_fetch_queue_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(DEPTH + MEM_LAT + 1);

  logic [MEM_LAT-1:0] r_dl_valid;
  logic [XLEN-1:0]    r_dl_pc [MEM_LAT];

  logic [XLEN-1:0]    r_fifo_pc    [DEPTH];
  logic [31:0]        r_fifo_instr [DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_count;

  logic               r_valid_out;
  logic [XLEN-1:0]    r_pc_out;
  logic [31:0]        r_instr_out;

  logic [OW-1:0]      w_dl_cnt;
  logic [OW-1:0]      w_occ;
  logic               w_full;
  logic               w_accept;
  logic               w_arrival;
  logic [XLEN-1:0]    w_arr_pc;
  logic               w_fifo_empty;
  logic               w_pop;
  logic               w_bypass;
  logic               w_push;
  logic               w_nxt_valid;
  logic [XLEN-1:0]    w_nxt_pc;
  logic [31:0]        w_nxt_instr;

  // Credit count: everything already issued that has not yet reached the output register
  always_comb begin
    w_dl_cnt = '0;
    for (int i = 0; i < MEM_LAT; i++) begin
      w_dl_cnt = w_dl_cnt + OW'(r_dl_valid[i]);
    end
    w_occ  = OW'(r_count) + w_dl_cnt;
    w_full = (w_occ >= OW'(DEPTH));
  end

  assign w_accept     = bus.req_valid & ~w_full & ~bus.flush;
  assign w_arrival    = r_dl_valid[MEM_LAT-1];
  assign w_arr_pc     = r_dl_pc[MEM_LAT-1];
  assign w_fifo_empty = (r_count == CW'(0));
  assign w_pop        = ~bus.stall & ~w_fifo_empty;
  assign w_bypass     = ~bus.stall & w_fifo_empty & w_arrival;
  assign w_push       = w_arrival & (bus.stall | ~w_fifo_empty);

  // Request delay line mirroring the memory pipeline
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dl_valid <= '0;
      for (int i = 0; i < MEM_LAT; i++) begin
        r_dl_pc[i] <= '0;
      end
    end else if (bus.flush) begin
      r_dl_valid <= '0;
    end else begin
      r_dl_valid[0] <= w_accept;
      r_dl_pc[0]    <= bus.req_pc;
      for (int i = 1; i < MEM_LAT; i++) begin
        r_dl_valid[i] <= r_dl_valid[i-1];
        r_dl_pc[i]    <= r_dl_pc[i-1];
      end
    end
  end

  // Skid FIFO storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_fifo_pc[i]    <= '0;
        r_fifo_instr[i] <= 32'h0000_0000;
      end
    end else if (w_push && !bus.flush) begin
      r_fifo_pc[r_wr_ptr]    <= w_arr_pc;
      r_fifo_instr[r_wr_ptr] <= bus.rsp_instr;
    end
  end

  // FIFO pointers and count; power-of-two depth lets the pointers wrap naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (bus.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Next output: FIFO head has priority over a fresh arrival so order is kept
  always_comb begin
    w_nxt_valid = r_valid_out;
    w_nxt_pc    = r_pc_out;
    w_nxt_instr = r_instr_out;
    if (bus.flush) begin
      w_nxt_valid = 1'b0;
      w_nxt_pc    = '0;
      w_nxt_instr = NOP;
    end else if (bus.stall) begin
      w_nxt_valid = r_valid_out;
      w_nxt_pc    = r_pc_out;
      w_nxt_instr = r_instr_out;
    end else if (w_pop) begin
      w_nxt_valid = 1'b1;
      w_nxt_pc    = r_fifo_pc[r_rd_ptr];
      w_nxt_instr = r_fifo_instr[r_rd_ptr];
    end else if (w_bypass) begin
      w_nxt_valid = 1'b1;
      w_nxt_pc    = w_arr_pc;
      w_nxt_instr = bus.rsp_instr;
    end else begin
      w_nxt_valid = 1'b0;
      w_nxt_pc    = '0;
      w_nxt_instr = NOP;
    end
  end

  // Output register toward decode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid_out <= 1'b0;
      r_pc_out    <= '0;
      r_instr_out <= NOP;
    end else begin
      r_valid_out <= w_nxt_valid;
      r_pc_out    <= w_nxt_pc;
      r_instr_out <= w_nxt_instr;
    end
  end

  assign bus.full      = w_full;
  assign bus.valid_out = r_valid_out;
  assign bus.pc_out    = r_pc_out;
  assign bus.instr_out = r_instr_out;

endmodule

// File: tb/tb_if_id_fetch_queue.sv
// Directed bench: table vectors on a DEPTH=2/MEM_LAT=1 queue, hand sequences on a
// MEM_LAT=2 queue, and a stall-randomised ordering run on a DEPTH=4 queue.
module tb_if_id_fetch_queue;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  if_id_fetch_queue_if #(.XLEN(32)) ifa ();
  if_id_fetch_queue_if #(.XLEN(32)) ifb ();
  if_id_fetch_queue_if #(.XLEN(32)) ifc ();

  if_id_fetch_queue #(.XLEN(32), .DEPTH(2), .MEM_LAT(1), .NOP(NOP)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  if_id_fetch_queue #(.XLEN(32), .DEPTH(2), .MEM_LAT(2), .NOP(NOP)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
  if_id_fetch_queue #(.XLEN(32), .DEPTH(4), .MEM_LAT(2), .NOP(NOP)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

  function automatic logic [31:0] ins(input logic [31:0] pc);
    return 32'hC0DE_0000 ^ pc;
  endfunction

  // Memory model for dut_c: returns the word for the PC requested two cycles ago
  logic [31:0] c_h1, c_h2;
  always @(posedge clk) begin
    c_h1 <= ifc.req_pc;
    c_h2 <= c_h1;
  end
  assign ifc.rsp_instr = ins(c_h2);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic        st;
    logic        fl;
    logic        rv;
    logic [31:0] pc;
    logic [31:0] rsp;
    logic        ef;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] ein;
  } vec_t;

  vec_t vq[$];

  task automatic addv(input logic st, input logic fl, input logic rv, input logic [31:0] pc,
                      input logic [31:0] rsp, input logic ef, input logic ev,
                      input logic [31:0] epc, input logic [31:0] ein);
    vec_t v;
    v.st = st; v.fl = fl; v.rv = rv; v.pc = pc; v.rsp = rsp;
    v.ef = ef; v.ev = ev; v.epc = epc; v.ein = ein;
    vq.push_back(v);
  endtask

  task automatic step_b(input string nm, input logic st, input logic fl, input logic rv,
                        input logic [31:0] pc, input logic [31:0] rsp, input logic ef,
                        input logic ev, input logic [31:0] epc, input logic [31:0] ein);
    ifb.stall = st; ifb.flush = fl; ifb.req_valid = rv; ifb.req_pc = pc; ifb.rsp_instr = rsp;
    #1;
    chk({nm, " full"}, 32'(ifb.full), 32'(ef));
    @(posedge clk); #1;
    chk({nm, " valid"}, 32'(ifb.valid_out), 32'(ev));
    chk({nm, " pc"}, ifb.pc_out, epc);
    chk({nm, " instr"}, ifb.instr_out, ein);
  endtask

  initial begin
    int          issued;
    int          delivered;
    int          cyc;
    int          occ;
    logic        st;
    logic        pv;
    logic [31:0] ppc;
    logic [31:0] pin;
    logic [31:0] epc;
    logic [31:0] exp_q[$];

    rst = 1'b1;
    ifa.stall = 1'b0; ifa.flush = 1'b0; ifa.req_valid = 1'b0; ifa.req_pc = 32'h0; ifa.rsp_instr = 32'h0;
    ifb.stall = 1'b0; ifb.flush = 1'b0; ifb.req_valid = 1'b0; ifb.req_pc = 32'h0; ifb.rsp_instr = 32'h0;
    ifc.stall = 1'b0; ifc.flush = 1'b0; ifc.req_valid = 1'b0; ifc.req_pc = 32'h0;
    #1;
    chk("rst valid", 32'(ifa.valid_out), 32'd0);
    chk("rst pc", ifa.pc_out, 32'h0);
    chk("rst instr", ifa.instr_out, NOP);
    chk("rst full", 32'(ifa.full), 32'd0);
    chk("rst c instr", ifc.instr_out, NOP);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // streaming
    addv(1'b0, 1'b0, 1'b1, 32'h00, JUNK,      1'b0, 1'b0, 32'h00, NOP);
    addv(1'b0, 1'b0, 1'b1, 32'h04, ins(32'h00), 1'b0, 1'b1, 32'h00, ins(32'h00));
    addv(1'b0, 1'b0, 1'b1, 32'h08, ins(32'h04), 1'b0, 1'b1, 32'h04, ins(32'h04));
    addv(1'b0, 1'b0, 1'b0, 32'h00, ins(32'h08), 1'b0, 1'b1, 32'h08, ins(32'h08));
    addv(1'b0, 1'b0, 1'b0, 32'h00, JUNK,      1'b0, 1'b0, 32'h00, NOP);
    // stall absorption; 0x1C is requested while full and must never appear
    addv(1'b0, 1'b0, 1'b1, 32'h10, JUNK,      1'b0, 1'b0, 32'h00, NOP);
    addv(1'b0, 1'b0, 1'b1, 32'h14, ins(32'h10), 1'b0, 1'b1, 32'h10, ins(32'h10));
    addv(1'b1, 1'b0, 1'b1, 32'h18, ins(32'h14), 1'b0, 1'b1, 32'h10, ins(32'h10));
    addv(1'b1, 1'b0, 1'b1, 32'h1C, ins(32'h18), 1'b1, 1'b1, 32'h10, ins(32'h10));
    addv(1'b1, 1'b0, 1'b1, 32'h1C, JUNK,      1'b1, 1'b1, 32'h10, ins(32'h10));
    addv(1'b0, 1'b0, 1'b0, 32'h00, JUNK,      1'b1, 1'b1, 32'h14, ins(32'h14));
    addv(1'b0, 1'b0, 1'b0, 32'h00, JUNK,      1'b0, 1'b1, 32'h18, ins(32'h18));
    addv(1'b0, 1'b0, 1'b0, 32'h00, JUNK,      1'b0, 1'b0, 32'h00, NOP);
    // flush during stall with a full FIFO
    addv(1'b0, 1'b0, 1'b1, 32'h40, JUNK,      1'b0, 1'b0, 32'h00, NOP);
    addv(1'b0, 1'b0, 1'b1, 32'h44, ins(32'h40), 1'b0, 1'b1, 32'h40, ins(32'h40));
    addv(1'b1, 1'b0, 1'b1, 32'h48, ins(32'h44), 1'b0, 1'b1, 32'h40, ins(32'h40));
    addv(1'b1, 1'b0, 1'b0, 32'h00, ins(32'h48), 1'b1, 1'b1, 32'h40, ins(32'h40));
    addv(1'b1, 1'b1, 1'b0, 32'h00, JUNK,      1'b1, 1'b0, 32'h00, NOP);
    addv(1'b0, 1'b0, 1'b0, 32'h00, JUNK,      1'b0, 1'b0, 32'h00, NOP);
    addv(1'b0, 1'b0, 1'b1, 32'h50, JUNK,      1'b0, 1'b0, 32'h00, NOP);
    addv(1'b0, 1'b0, 1'b0, 32'h00, ins(32'h50), 1'b0, 1'b1, 32'h50, ins(32'h50));
    // flush drops both the arriving word and the same-cycle request
    addv(1'b0, 1'b0, 1'b1, 32'h60, JUNK,      1'b0, 1'b0, 32'h00, NOP);
    addv(1'b0, 1'b1, 1'b1, 32'h64, ins(32'h60), 1'b0, 1'b0, 32'h00, NOP);
    addv(1'b0, 1'b0, 1'b0, 32'h00, ins(32'h64), 1'b0, 1'b0, 32'h00, NOP);

    foreach (vq[k]) begin
      ifa.stall = vq[k].st; ifa.flush = vq[k].fl; ifa.req_valid = vq[k].rv;
      ifa.req_pc = vq[k].pc; ifa.rsp_instr = vq[k].rsp;
      #1;
      chk($sformatf("v%0d full", k), 32'(ifa.full), 32'(vq[k].ef));
      @(posedge clk); #1;
      chk($sformatf("v%0d valid", k), 32'(ifa.valid_out), 32'(vq[k].ev));
      chk($sformatf("v%0d pc", k), ifa.pc_out, vq[k].epc);
      chk($sformatf("v%0d instr", k), ifa.instr_out, vq[k].ein);
    end
    ifa.req_valid = 1'b0; ifa.flush = 1'b0; ifa.stall = 1'b0;

    // flush with in-flight requests, MEM_LAT=2
    step_b("f0", 1'b0, 1'b0, 1'b1, 32'h20, JUNK,        1'b0, 1'b0, 32'h0, NOP);
    step_b("f1", 1'b0, 1'b1, 1'b1, 32'h24, JUNK,        1'b0, 1'b0, 32'h0, NOP);
    step_b("f2", 1'b0, 1'b0, 1'b1, 32'h80, ins(32'h20), 1'b0, 1'b0, 32'h0, NOP);
    step_b("f3", 1'b0, 1'b0, 1'b0, 32'h00, ins(32'h24), 1'b0, 1'b0, 32'h0, NOP);
    step_b("f4", 1'b0, 1'b0, 1'b0, 32'h00, ins(32'h80), 1'b0, 1'b1, 32'h80, ins(32'h80));
    // fill FIFO and delay line under stall, then reset between edges
    step_b("r0", 1'b1, 1'b0, 1'b1, 32'h30, JUNK,        1'b0, 1'b1, 32'h80, ins(32'h80));
    step_b("r1", 1'b1, 1'b0, 1'b1, 32'h34, JUNK,        1'b0, 1'b1, 32'h80, ins(32'h80));
    step_b("r2", 1'b1, 1'b0, 1'b0, 32'h00, ins(32'h30), 1'b1, 1'b1, 32'h80, ins(32'h80));
    #1;
    chk("r3 full before rst", 32'(ifb.full), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async rst valid", 32'(ifb.valid_out), 32'd0);
    chk("async rst pc", ifb.pc_out, 32'h0);
    chk("async rst instr", ifb.instr_out, NOP);
    chk("async rst full", 32'(ifb.full), 32'd0);
    #1;
    rst = 1'b0;
    step_b("r4", 1'b0, 1'b0, 1'b0, 32'h00, ins(32'h34), 1'b0, 1'b0, 32'h0, NOP);
    step_b("r5", 1'b0, 1'b0, 1'b1, 32'h90, JUNK,        1'b0, 1'b0, 32'h0, NOP);
    step_b("r6", 1'b0, 1'b0, 1'b0, 32'h00, JUNK,        1'b0, 1'b0, 32'h0, NOP);
    step_b("r7", 1'b0, 1'b0, 1'b0, 32'h00, ins(32'h90), 1'b0, 1'b1, 32'h90, ins(32'h90));

    // ordering through DEPTH=4 pointer wrap with random stalls
    issued = 0; delivered = 0; cyc = 0;
    while (delivered < 20 && cyc < 500) begin
      occ = issued - delivered;
      st  = ($urandom_range(0, 2) == 0);
      ifc.stall = st;
      if (occ >= 4) begin
        ifc.req_valid = ($urandom_range(0, 1) == 1);
        ifc.req_pc    = 32'h0000_BAD0;
      end else if (issued < 20 && $urandom_range(0, 3) != 0) begin
        ifc.req_valid = 1'b1;
        ifc.req_pc    = 32'h100 + 32'(issued * 4);
        exp_q.push_back(ifc.req_pc);
        issued++;
      end else begin
        ifc.req_valid = 1'b0;
        ifc.req_pc    = 32'h0;
      end
      #1;
      chk($sformatf("w%0d full", cyc), 32'(ifc.full), 32'(occ >= 4));
      pv = ifc.valid_out; ppc = ifc.pc_out; pin = ifc.instr_out;
      @(posedge clk); #1;
      if (st) begin
        chk($sformatf("w%0d hold valid", cyc), 32'(ifc.valid_out), 32'(pv));
        chk($sformatf("w%0d hold pc", cyc), ifc.pc_out, ppc);
        chk($sformatf("w%0d hold instr", cyc), ifc.instr_out, pin);
      end else if (ifc.valid_out) begin
        if (exp_q.size() == 0) begin
          chk($sformatf("w%0d unexpected pc", cyc), ifc.pc_out, 32'hFFFF_FFFF);
        end else begin
          epc = exp_q.pop_front();
          chk($sformatf("w%0d pc", cyc), ifc.pc_out, epc);
          chk($sformatf("w%0d instr", cyc), ifc.instr_out, ins(epc));
        end
        delivered++;
      end
      cyc++;
    end
    ifc.req_valid = 1'b0; ifc.stall = 1'b0;
    chk("wrap delivered", 32'(delivered), 32'd20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
